// File: rtl/alu_operand_stage.sv
// Operand-fetch stage ahead of the 16-bit ALU: 8x16 register file with write-through bypass,
// immediate extension for operand B, and a registered op_a/op_b pair behind a valid/ready handshake.
module alu_operand_stage #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int ADDR_W = 3,
    parameter int IMM_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [IMM_W-1:0]  imm,
    input  logic              use_imm,
    input  logic              imm_zext,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] opA_q;
    logic [DATA_W-1:0] opB_q;

    logic [DATA_W-1:0] rdA;
    logic [DATA_W-1:0] rdB;
    logic [DATA_W-1:0] immExt;
    logic [DATA_W-1:0] opB_d;
    logic              accept;

    // Read ports: r0 is constant zero, a same-cycle write-back is forwarded ahead of the array.
    always_comb begin
        rdA = '0;
        if (rs_addr != '0) begin
            if (wb_en && (wb_addr == rs_addr)) begin
                rdA = wb_data;
            end else begin
                rdA = regs_q[rs_addr];
            end
        end
    end

    always_comb begin
        rdB = '0;
        if (rt_addr != '0) begin
            if (wb_en && (wb_addr == rt_addr)) begin
                rdB = wb_data;
            end else begin
                rdB = regs_q[rt_addr];
            end
        end
    end

    always_comb begin
        if (imm_zext) begin
            immExt = {{(DATA_W-IMM_W){1'b0}}, imm};
        end else begin
            immExt = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        end
        opB_d = use_imm ? immExt : rdB;
    end

    // Write-back is independent of the handshake, so flushes and stalls never lose a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    // Flush wins over a simultaneous accept; the operands keep their last values when emptied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            opA_q   <= '0;
            opB_q   <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
        end else if (accept) begin
            state_q <= FULL;
            opA_q   <= rdA;
            opB_q   <= opB_d;
        end else if (out_valid && out_ready) begin
            state_q <= EMPTY;
        end
    end

    assign op_a = opA_q;
    assign op_b = opB_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios with literal expectations, then random traffic
// compared every cycle against a behavioural register-file/handshake model.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  rs_addr;
    logic [2:0]  rt_addr;
    logic [7:0]  imm;
    logic        use_imm;
    logic        imm_zext;
    logic        flush;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;

    int checks = 0;
    int errors = 0;
    bit running = 1'b0;

    logic [15:0] modelMem [8];
    logic        expValid;
    logic [15:0] expA;
    logic [15:0] expB;

    alu_operand_stage dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .imm      (imm),
        .use_imm  (use_imm),
        .imm_zext (imm_zext),
        .flush    (flush),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .op_a     (op_a),
        .op_b     (op_b)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then return just after the following falling edge.
    task automatic applyStimulus(input logic iv, input logic [2:0] rs, input logic [2:0] rt,
                                 input logic [7:0] im, input logic ui, input logic zx,
                                 input logic fl, input logic we, input logic [2:0] wa,
                                 input logic [15:0] wd, input logic ordy);
        in_valid  = iv;
        rs_addr   = rs;
        rt_addr   = rt;
        imm       = im;
        use_imm   = ui;
        imm_zext  = zx;
        flush     = fl;
        wb_en     = we;
        wb_addr   = wa;
        wb_data   = wd;
        out_ready = ordy;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [15:0] readModel(input logic [2:0] a);
        if (a == 3'd0) return 16'h0000;
        if (wb_en && wb_addr == a) return wb_data;
        return modelMem[a];
    endfunction

    // Behavioural model: architectural registers plus the one-deep operand holding slot.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) modelMem[i] = 16'h0000;
            expValid = 1'b0;
            expA     = 16'h0000;
            expB     = 16'h0000;
        end else begin
            logic acc;
            acc = in_valid && (!expValid || out_ready);
            if (flush) begin
                expValid = 1'b0;
            end else if (acc) begin
                expValid = 1'b1;
                expA     = readModel(rs_addr);
                if (use_imm) expB = imm_zext ? {8'h00, imm} : {{8{imm[7]}}, imm};
                else         expB = readModel(rt_addr);
            end else if (expValid && out_ready) begin
                expValid = 1'b0;
            end
            if (wb_en && wb_addr != 3'd0) modelMem[wb_addr] = wb_data;
        end
    end

    // Per-cycle comparison against the model; in_ready is checked once the new inputs are driven.
    always begin
        @(negedge clk);
        if (running && !reset) begin
            checkOutput("out_valid", {15'b0, out_valid}, {15'b0, expValid});
            checkOutput("op_a", op_a, expA);
            checkOutput("op_b", op_b, expB);
        end
        #2;
        if (running && !reset) begin
            checkOutput("in_ready", {15'b0, in_ready}, {15'b0, (!expValid || out_ready)});
        end
    end

    initial begin
        reset = 1'b1;
        in_valid = 0; rs_addr = 0; rt_addr = 0; imm = 0; use_imm = 0; imm_zext = 0;
        flush = 0; wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 1;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        running = 1'b1;
        checkOutput("reset_out_valid", {15'b0, out_valid}, 16'h0000);
        checkOutput("reset_op_a", op_a, 16'h0000);
        checkOutput("reset_in_ready", {15'b0, in_ready}, 16'h0001);

        $display("[TB] reading r1..r7 after reset");
        for (int r = 1; r < 8; r++) begin
            applyStimulus(1, 3'(r), 3'(r), 8'h00, 0, 0, 0, 0, 0, 16'h0, 1);
            checkOutput("read_valid", {15'b0, out_valid}, 16'h0001);
            checkOutput("read_op_a", op_a, 16'h0000);
            checkOutput("read_op_b", op_b, 16'h0000);
        end

        $display("[TB] write-back and r0");
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 1, 3'd3, 16'hA5A5, 1);
        applyStimulus(1, 3'd3, 3'd0, 8'h00, 0, 0, 0, 0, 0, 16'h0, 1);
        checkOutput("wb_r3_op_a", op_a, 16'hA5A5);
        checkOutput("wb_r3_op_b", op_b, 16'h0000);
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 1, 3'd0, 16'hFFFF, 1);
        applyStimulus(1, 3'd0, 3'd0, 8'h00, 0, 0, 0, 0, 0, 16'h0, 1);
        checkOutput("r0_op_a", op_a, 16'h0000);

        $display("[TB] bypass");
        applyStimulus(1, 3'd5, 3'd3, 8'h00, 0, 0, 0, 1, 3'd5, 16'h1234, 1);
        checkOutput("bypass_op_a", op_a, 16'h1234);
        checkOutput("bypass_op_b", op_b, 16'hA5A5);

        $display("[TB] immediate extension");
        applyStimulus(1, 3'd0, 3'd0, 8'h80, 1, 0, 0, 0, 0, 16'h0, 1);
        checkOutput("imm_sext", op_b, 16'hFF80);
        applyStimulus(1, 3'd0, 3'd0, 8'h80, 1, 1, 0, 0, 0, 16'h0, 1);
        checkOutput("imm_zext", op_b, 16'h0080);

        $display("[TB] stall then release");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 3'd3, 3'd3, 8'h00, 0, 0, 0, 0, 0, 16'h0, 0);
            checkOutput("stall_in_ready", {15'b0, in_ready}, 16'h0000);
            checkOutput("stall_op_b", op_b, 16'h0080);
            checkOutput("stall_valid", {15'b0, out_valid}, 16'h0001);
        end
        applyStimulus(1, 3'd5, 3'd0, 8'h00, 0, 0, 0, 0, 0, 16'h0, 1);
        checkOutput("release_valid", {15'b0, out_valid}, 16'h0001);
        checkOutput("release_op_a", op_a, 16'h1234);

        $display("[TB] flush and mid-stall reset");
        applyStimulus(1, 3'd3, 3'd3, 8'h00, 0, 0, 1, 0, 0, 16'h0, 1);
        checkOutput("flush_valid", {15'b0, out_valid}, 16'h0000);
        checkOutput("flush_op_a_kept", op_a, 16'h1234);
        applyStimulus(1, 3'd3, 3'd0, 8'h00, 0, 0, 0, 0, 0, 16'h0, 1);
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 16'h0, 0);
        checkOutput("prestall_valid", {15'b0, out_valid}, 16'h0001);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_valid", {15'b0, out_valid}, 16'h0000);
        checkOutput("async_reset_op_a", op_a, 16'h0000);
        @(negedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] random traffic");
        for (int n = 0; n < 2000; n++) begin
            applyStimulus(($urandom_range(0, 9) < 7), 3'($urandom), 3'($urandom), 8'($urandom),
                          1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 1) == 1), 3'($urandom), 16'($urandom),
                          ($urandom_range(0, 9) < 7));
        end

        running = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
